// File: rtl/alu16_op_driver_if.sv
// Request, ALU-side and response signals of the ALU16 sequencing front-end.
// slave = the driver block; master = requester, ALU and response consumer.
interface alu16_op_driver_if #(
   parameter int WIDTH = 16
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic [1:0]       req_op;
   logic [3:0]       req_tag;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic             alu_sel0;
   logic             alu_sel1;
   logic [WIDTH-1:0] alu_out;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic [3:0]       rsp_tag;
   logic             busy;

   modport slave (
      input  req_valid, req_a, req_b, req_op, req_tag, alu_out, rsp_ready,
      output req_ready, alu_a, alu_b, alu_sel0, alu_sel1,
             rsp_valid, rsp_result, rsp_tag, busy
   );

   modport master (
      output req_valid, req_a, req_b, req_op, req_tag, alu_out, rsp_ready,
      input  req_ready, alu_a, alu_b, alu_sel0, alu_sel1,
             rsp_valid, rsp_result, rsp_tag, busy
   );
endinterface

// File: rtl/alu16_op_driver.sv
// ALU16 sequencer: latch request, hold ALU inputs SETTLE_CYCLES, push {alu_out,tag} to a result FIFO.
// Latency accept->push = SETTLE_CYCLES edges; req_ready drops while driving or when the FIFO is full.
module alu16_op_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_vld,
   input  logic [W-1:0]           push_dat,
   input  logic                   pop_rdy,
   output logic                   pop_vld,
   output logic [W-1:0]           pop_dat,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign do_pop  = pop_rdy && (cnt_q != '0);
   assign do_push = push_vld && ((cnt_q != (AW+1)'(DEPTH)) || do_pop);

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (do_push) begin
         mem_d[wr_q] = push_dat;
         wr_d        = wr_q + 1'b1;
      end
      if (do_pop) begin
         rd_d = rd_q + 1'b1;
      end
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign pop_vld = (cnt_q != '0);
   assign pop_dat = mem_q[rd_q];
   assign count   = cnt_q;
endmodule

module alu16_op_driver #(
   parameter int WIDTH         = 16,
   parameter int SETTLE_CYCLES = 1,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   alu16_op_driver_if.slave  bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic [3:0]       tag;
   } rsp_t;

   typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [1:0]       op_q, op_d;
   logic [3:0]       tag_q, tag_d;
   logic             accept, push;
   rsp_t             push_dat, head;
   logic [CW-1:0]    fifo_cnt;
   logic             fifo_vld;

   // Only one op is ever in flight, so this full check is what keeps the push from overflowing.
   assign bus.req_ready = (state_q == IDLE) && (fifo_cnt < CW'(FIFO_DEPTH));
   assign accept        = bus.req_valid && bus.req_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      alu_a_d = alu_a_q;
      alu_b_d = alu_b_q;
      op_d    = op_q;
      tag_d   = tag_q;
      push    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               alu_a_d = bus.req_a;
               alu_b_d = bus.req_b;
               op_d    = bus.req_op;
               tag_d   = bus.req_tag;
               cnt_d   = 4'(SETTLE_CYCLES - 1);
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               push    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         alu_a_q <= '0;
         alu_b_q <= '0;
         op_q    <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         alu_a_q <= alu_a_d;
         alu_b_q <= alu_b_d;
         op_q    <= op_d;
         tag_q   <= tag_d;
      end
   end

   assign push_dat.result = bus.alu_out;
   assign push_dat.tag    = tag_q;

   alu16_op_fifo #(
      .W     ($bits(rsp_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_vld (push),
      .push_dat (push_dat),
      .pop_rdy  (bus.rsp_ready),
      .pop_vld  (fifo_vld),
      .pop_dat  (head),
      .count    (fifo_cnt)
   );

   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_sel0   = op_q[0];
   assign bus.alu_sel1   = op_q[1];
   assign bus.busy       = (state_q == DRIVE);
   assign bus.rsp_valid  = fifo_vld;
   assign bus.rsp_result = head.result;
   assign bus.rsp_tag    = head.tag;
endmodule
